// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS-422 loopback bit-error tester.
// Provides the FSM state encoding, pattern-mode constants, PRBS7 tap and
// seed constants, and the per-channel seed helper.
package rs422_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PRBS7  = 1'b1;

  // x^7 + x^6 + 1: feedback is the XOR of the two most significant bits.
  localparam int             PRBS_W     = 7;
  localparam int             PRBS_TAP_A = 6;
  localparam int             PRBS_TAP_B = 5;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h7F;

  // Each channel gets a distinct, never-zero seed (NCH <= 64).
  function automatic logic [PRBS_W-1:0] chan_seed(input int unsigned ch);
    return PRBS_SEED ^ PRBS_W'(ch);
  endfunction

endpackage

// File: rtl/rs422_loopback_tester_if.sv
// Control/status bus between the test-control register block and the tester.
// master: register block (drives start/abort/configuration, reads status).
// slave : tester (reads configuration, drives busy/finish/aborted/counters).
interface rs422_loopback_tester_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int ERR_W = 32,
  parameter int LAT_W = 4
);
  logic                 start;
  logic                 abort;
  logic                 mode;
  logic [CNT_W-1:0]     pkt_len;
  logic [LAT_W-1:0]     rx_lat;
  logic [NCH-1:0]       chan_en;
  logic                 busy;
  logic                 finish;
  logic                 aborted;
  logic [CNT_W-1:0]     bit_cnt;
  logic [NCH*ERR_W-1:0] err_cnt;
  logic                 err_any;

  modport master (
    output start, abort, mode, pkt_len, rx_lat, chan_en,
    input  busy, finish, aborted, bit_cnt, err_cnt, err_any
  );

  modport slave (
    input  start, abort, mode, pkt_len, rx_lat, chan_en,
    output busy, finish, aborted, bit_cnt, err_cnt, err_any
  );
endinterface

// File: rtl/rs422_pattern_gen.sv
// Per-channel test pattern source: toggle or PRBS7 (x^7+x^6+1).
// Ports: sys_clk/sys_rst (sync, active-high), load (reseed), adv (step the
// pattern), mode (0 toggle, 1 PRBS7), seed (PRBS7 seed), pat_bit (the bit the
// next advance produces, so the caller can register it in the same cycle).
module rs422_pattern_gen
  import rs422_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              load,
  input  logic              adv,
  input  logic              mode,
  input  logic [PRBS_W-1:0] seed,
  output logic              pat_bit
);

  logic              r_tog;
  logic [PRBS_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb = r_lfsr[PRBS_TAP_A] ^ r_lfsr[PRBS_TAP_B];

  always_ff @(posedge sys_clk) begin
    if (sys_rst || load) begin
      r_tog  <= 1'b0;
      r_lfsr <= seed;
    end else if (adv) begin
      r_tog  <= ~r_tog;
      r_lfsr <= {r_lfsr[PRBS_W-2:0], w_fb};
    end
  end

  // After a shift the MSB is the current bit just below it.
  assign pat_bit = (mode == MODE_PRBS7) ? r_lfsr[PRBS_W-2] : ~r_tog;

endmodule

// File: rtl/rs422_loopback_tester.sv
// Multi-channel RS-422 loopback bit-error tester.
// Ports: sys_clk/sys_rst (sync, active-high); ctrl (slave side of the
// control/status bus); rs422_in (looped-back receive lines); rs422_di
// (registered transmit lines). Each bit is driven in SEND, allowed rx_lat
// cycles in WAIT, then compared in CHECK against the looped-back line.
module rs422_loopback_tester
  import rs422_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int ERR_W = 32,
  parameter int LAT_W = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  rs422_loopback_tester_if.slave ctrl,
  input  logic [NCH-1:0]        rs422_in,
  output logic [NCH-1:0]        rs422_di
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  state_t           r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_len;
  logic [LAT_W-1:0] r_lat;
  logic [LAT_W-1:0] r_wait;
  logic [NCH-1:0]   r_en;
  logic [NCH-1:0]   r_di;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [ERR_W-1:0] r_err [NCH];
  logic             r_busy;
  logic             r_finish;
  logic             r_aborted;

  logic             w_accept;
  logic [NCH-1:0]   w_adv;
  logic [NCH-1:0]   w_pat;
  logic [CNT_W-1:0] w_bit_nxt;

  // Abort has priority over start; start is only seen when not running.
  assign w_accept  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                     ctrl.start && !ctrl.abort;
  assign w_adv     = (r_state == ST_SEND && !ctrl.abort) ? r_en : '0;
  assign w_bit_nxt = r_bit_cnt + CNT_W'(1);

  for (genvar g = 0; g < NCH; g++) begin : g_pat
    rs422_pattern_gen u_pat (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .load    (w_accept),
      .adv     (w_adv[g]),
      .mode    (r_mode),
      .seed    (chan_seed(g)),
      .pat_bit (w_pat[g])
    );
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_TOGGLE;
      r_len     <= '0;
      r_lat     <= '0;
      r_wait    <= '0;
      r_en      <= '0;
      r_di      <= '0;
      r_bit_cnt <= '0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_aborted <= 1'b0;
      for (int i = 0; i < NCH; i++) r_err[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_mode    <= ctrl.mode;
            r_len     <= ctrl.pkt_len;
            r_lat     <= ctrl.rx_lat;
            r_en      <= ctrl.chan_en;
            r_di      <= '0;
            r_bit_cnt <= '0;
            r_aborted <= 1'b0;
            for (int i = 0; i < NCH; i++) r_err[i] <= '0;
            if (ctrl.pkt_len == '0) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_finish <= 1'b1;
            end else begin
              r_state  <= ST_SEND;
              r_busy   <= 1'b1;
              r_finish <= 1'b0;
            end
          end
        end
        // Drive stage: register the next pattern bit on enabled lines.
        ST_SEND: begin
          if (ctrl.abort) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_finish  <= 1'b1;
            r_aborted <= 1'b1;
          end else begin
            r_di <= w_pat & r_en;
            if (r_lat != '0) begin
              r_state <= ST_WAIT;
              r_wait  <= r_lat;
            end else begin
              r_state <= ST_CHECK;
            end
          end
        end
        // Latency stage: let the loop settle for rx_lat cycles.
        ST_WAIT: begin
          if (ctrl.abort) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_finish  <= 1'b1;
            r_aborted <= 1'b1;
          end else if (r_wait == LAT_W'(1)) begin
            r_state <= ST_CHECK;
          end else begin
            r_wait <= r_wait - LAT_W'(1);
          end
        end
        // Compare stage: an abort here discards the comparison entirely.
        ST_CHECK: begin
          if (ctrl.abort) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_finish  <= 1'b1;
            r_aborted <= 1'b1;
          end else begin
            for (int i = 0; i < NCH; i++) begin
              if (r_en[i] && (rs422_in[i] != r_di[i])) r_err[i] <= sat_inc(r_err[i]);
            end
            r_bit_cnt <= w_bit_nxt;
            if (w_bit_nxt == r_len) begin
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_finish <= 1'b1;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  logic [NCH*ERR_W-1:0] w_err_flat;
  logic                 w_err_any;

  always_comb begin
    w_err_flat = '0;
    w_err_any  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_err_flat[i*ERR_W +: ERR_W] = r_err[i];
      if (r_err[i] != '0) w_err_any = 1'b1;
    end
  end

  assign rs422_di     = r_di;
  assign ctrl.busy    = r_busy;
  assign ctrl.finish  = r_finish;
  assign ctrl.aborted = r_aborted;
  assign ctrl.bit_cnt = r_bit_cnt;
  assign ctrl.err_cnt = w_err_flat;
  assign ctrl.err_any = w_err_any;

endmodule

// File: tb/tb_rs422_loopback_tester.sv
module tb_rs422_loopback_tester;
  localparam int NCH = 4, CNT_W = 16, ERR_W = 32, LAT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs422_loopback_tester_if #(.NCH(NCH), .CNT_W(CNT_W), .ERR_W(ERR_W), .LAT_W(LAT_W)) ctrl ();

  logic [NCH-1:0] rin, di, di_d;
  // Loop kinds: 0 direct, 1 inverted, 2 stuck 0, 3 stuck 1, 4 delayed 1 cycle.
  logic [2:0]     kind [NCH];

  always @(posedge clk) di_d <= di;
  always_comb begin
    rin = '0;
    for (int i = 0; i < NCH; i++) begin
      case (kind[i])
        3'd0:    rin[i] = di[i];
        3'd1:    rin[i] = ~di[i];
        3'd2:    rin[i] = 1'b0;
        3'd3:    rin[i] = 1'b1;
        default: rin[i] = di_d[i];
      endcase
    end
  end

  rs422_loopback_tester #(.NCH(NCH), .CNT_W(CNT_W), .ERR_W(ERR_W), .LAT_W(LAT_W)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .ctrl    (ctrl.slave),
    .rs422_in(rin),
    .rs422_di(di)
  );

  int n_tests = 0, n_fail = 0;
  int run_cyc;
  logic [NCH-1:0] cap [$];
  bit ref_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [ERR_W-1:0] err_of(input int ch);
    return ctrl.err_cnt[ch*ERR_W +: ERR_W];
  endfunction

  // Reference pattern: toggle is 1,0,1,...; PRBS7 uses a[n] = a[n-6]^a[n-7]
  // with the seed as the seven oldest history bits, output k = a[k-7].
  task automatic model_fill(input logic m, input int ch, input int len);
    bit a [$];
    logic [6:0] seed;
    ref_q.delete();
    if (m == 1'b0) begin
      for (int k = 1; k <= len; k++) ref_q.push_back(k % 2 == 1);
    end else begin
      seed = 7'h7F ^ 7'(ch);
      for (int j = 0; j < 7; j++) a.push_back(seed[6-j]);
      while (a.size() <= len) a.push_back(a[a.size()-6] ^ a[a.size()-7]);
      for (int k = 1; k <= len; k++) ref_q.push_back(a[k]);
    end
  endtask

  task automatic do_run(input logic m, input int len, input int lat, input logic [NCH-1:0] en);
    int p, limit;
    p = lat + 2;
    limit = len * p + 20;
    @(negedge clk);
    ctrl.mode = m; ctrl.pkt_len = CNT_W'(len); ctrl.rx_lat = LAT_W'(lat);
    ctrl.chan_en = en; ctrl.start = 1'b1;
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    if (len > 0) chk("busy after start", ctrl.busy, 1);
    cap.delete();
    run_cyc = 0;
    while (!ctrl.finish && run_cyc < limit) begin
      @(posedge clk); #1;
      run_cyc++;
      if ((run_cyc - 1) % p == 0) cap.push_back(di);
    end
    chk("finish reached", ctrl.finish, 1);
  endtask

  task automatic chk_stream(input string tag, input logic m, input int len, input logic [NCH-1:0] en);
    chk($sformatf("%s bits captured", tag), cap.size(), len);
    for (int i = 0; i < NCH; i++) begin
      int nbad = 0;
      model_fill(m, i, len);
      for (int k = 0; k < len && k < cap.size(); k++)
        if (cap[k][i] !== (en[i] ? ref_q[k] : 1'b0)) nbad++;
      chk($sformatf("%s stream ch%0d bad bits", tag, i), nbad, 0);
    end
  endtask

  typedef struct {
    logic             m;
    int               len;
    int               lat;
    logic [NCH-1:0]   en;
    logic [3*NCH-1:0] kinds;
    logic [8*NCH-1:0] errs;
    int               cyc;
  } vec_t;

  vec_t vt [7];

  initial begin
    int tick;
    logic [NCH-1:0] ren;
    logic rm;
    int rlen, rlat;
    longint exp_e;

    ctrl.start = 0; ctrl.abort = 0; ctrl.mode = 0; ctrl.pkt_len = '0;
    ctrl.rx_lat = '0; ctrl.chan_en = '0;
    for (int i = 0; i < NCH; i++) kind[i] = 3'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", ctrl.busy, 0);
    chk("reset finish", ctrl.finish, 0);
    chk("reset aborted", ctrl.aborted, 0);
    chk("reset bit_cnt", ctrl.bit_cnt, 0);
    chk("reset err_cnt", ctrl.err_cnt[63:0], 0);
    chk("reset di", di, 0);
    @(negedge clk); rst = 1'b0;

    vt[0] = '{1'b0,   8, 2, 4'hF, 12'h924, 32'h00000000,  32};
    vt[1] = '{1'b0,  10, 1, 4'hF, 12'h080, 32'h00050000,  30};
    vt[2] = '{1'b0,   6, 0, 4'hA, 12'h6DB, 32'h03000300,  12};
    vt[3] = '{1'b1, 127, 0, 4'hF, 12'h000, 32'h00000000, 254};
    vt[4] = '{1'b0,   0, 3, 4'hF, 12'h000, 32'h00000000,   0};
    vt[5] = '{1'b0,   5, 3, 4'hF, 12'h249, 32'h05050505,  25};
    vt[6] = '{1'b1,  20, 1, 4'h1, 12'h249, 32'h00000014,  60};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NCH; i++) kind[i] = vt[v].kinds[3*i +: 3];
      do_run(vt[v].m, vt[v].len, vt[v].lat, vt[v].en);
      chk($sformatf("vec%0d cycles", v), run_cyc, vt[v].cyc);
      chk($sformatf("vec%0d bit_cnt", v), ctrl.bit_cnt, vt[v].len);
      chk($sformatf("vec%0d busy", v), ctrl.busy, 0);
      chk($sformatf("vec%0d aborted", v), ctrl.aborted, 0);
      for (int i = 0; i < NCH; i++)
        chk($sformatf("vec%0d err ch%0d", v, i), err_of(i), vt[v].errs[8*i +: 8]);
      chk($sformatf("vec%0d err_any", v), ctrl.err_any, vt[v].errs != 0);
      chk_stream($sformatf("vec%0d", v), vt[v].m, vt[v].len, vt[v].en);
      if (v == 3) begin
        logic [6:0] first7;
        for (int k = 0; k < 7; k++) first7[6-k] = cap[k][0];
        chk("prbs ch0 first 7 bits", first7, 7'b1111110);
      end
    end

    // PRBS7 period: a 254-bit run must repeat itself after 127 bits.
    for (int i = 0; i < NCH; i++) kind[i] = 3'd0;
    do_run(1'b1, 254, 0, 4'h1);
    begin
      int nbad = 0;
      for (int k = 0; k < 127; k++) if (cap[k][0] !== cap[k+127][0]) nbad++;
      chk("prbs repeat at bit 128", nbad, 0);
      chk("prbs bit128 equals bit1", cap[127][0], 1'b1);
    end

    // Randomized runs against the reference pattern model.
    for (int r = 0; r < 8; r++) begin
      rm   = 1'($urandom_range(0, 1));
      rlen = $urandom_range(1, 40);
      rlat = $urandom_range(0, 3);
      ren  = NCH'($urandom);
      for (int i = 0; i < NCH; i++) kind[i] = 3'($urandom_range(0, 3));
      do_run(rm, rlen, rlat, ren);
      chk($sformatf("rnd%0d cycles", r), run_cyc, rlen * (rlat + 2));
      chk($sformatf("rnd%0d bit_cnt", r), ctrl.bit_cnt, rlen);
      for (int i = 0; i < NCH; i++) begin
        model_fill(rm, i, rlen);
        exp_e = 0;
        if (ren[i]) begin
          for (int k = 0; k < rlen; k++) begin
            case (kind[i])
              3'd1:    exp_e++;
              3'd2:    if (ref_q[k]) exp_e++;
              3'd3:    if (!ref_q[k]) exp_e++;
              default: ;
            endcase
          end
        end
        chk($sformatf("rnd%0d err ch%0d", r, i), err_of(i), exp_e);
      end
      chk_stream($sformatf("rnd%0d", r), rm, rlen, ren);
    end

    // Abort in WAIT of bit 5, then start+abort together in DONE.
    for (int i = 0; i < NCH; i++) kind[i] = 3'd0;
    @(negedge clk);
    ctrl.mode = 0; ctrl.pkt_len = 100; ctrl.rx_lat = 2; ctrl.chan_en = 4'hF;
    ctrl.start = 1;
    @(posedge clk); #1; ctrl.start = 0;
    repeat (17) @(posedge clk);
    #1;
    ctrl.abort = 1; ctrl.start = 1;
    @(posedge clk); #1;
    ctrl.abort = 0; ctrl.start = 0;
    chk("abort finish", ctrl.finish, 1);
    chk("abort aborted", ctrl.aborted, 1);
    chk("abort busy", ctrl.busy, 0);
    chk("abort bit_cnt", ctrl.bit_cnt, 4);
    ctrl.abort = 1; ctrl.start = 1;
    @(posedge clk); #1;
    ctrl.abort = 0; ctrl.start = 0;
    @(posedge clk); #1;
    chk("start+abort ignored aborted", ctrl.aborted, 1);
    chk("start+abort ignored busy", ctrl.busy, 0);
    chk("start+abort ignored bit_cnt", ctrl.bit_cnt, 4);

    // Start and configuration changes while busy have no effect.
    for (int i = 0; i < NCH; i++) kind[i] = 3'd1;
    @(negedge clk);
    ctrl.mode = 0; ctrl.pkt_len = 50; ctrl.rx_lat = 0; ctrl.chan_en = 4'hF;
    ctrl.start = 1;
    @(posedge clk); #1; ctrl.start = 0;
    tick = 0;
    repeat (5) begin @(posedge clk); #1; tick++; end
    ctrl.pkt_len = 3; ctrl.rx_lat = 5; ctrl.chan_en = 4'h0; ctrl.mode = 1; ctrl.start = 1;
    @(posedge clk); #1; tick++; ctrl.start = 0;
    repeat (14) begin @(posedge clk); #1; tick++; end
    chk("busy start ignored busy", ctrl.busy, 1);
    chk("busy start ignored bit_cnt", ctrl.bit_cnt, 10);
    chk("busy start ignored err ch3", err_of(3), 10);
    while (!ctrl.finish && tick < 200) begin @(posedge clk); #1; tick++; end
    chk("busy run cycles", tick, 100);
    chk("busy run bit_cnt", ctrl.bit_cnt, 50);
    chk("busy run err ch0", err_of(0), 50);

    // Reset mid-run returns everything to zero on the next edge.
    @(negedge clk);
    ctrl.pkt_len = 50; ctrl.rx_lat = 1; ctrl.chan_en = 4'hF; ctrl.mode = 0; ctrl.start = 1;
    @(posedge clk); #1; ctrl.start = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset err_any", ctrl.err_any, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid reset busy", ctrl.busy, 0);
    chk("mid reset finish", ctrl.finish, 0);
    chk("mid reset bit_cnt", ctrl.bit_cnt, 0);
    chk("mid reset err_cnt", ctrl.err_cnt[63:0], 0);
    chk("mid reset err_any", ctrl.err_any, 0);
    chk("mid reset di", di, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: actual 0 required 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rs422_loopback_tester.md
Name: rs422_loopback_tester

Overview:
- Multi-channel RS-422 loopback bit-error tester.
- Drives a test pattern on NCH transmit lines and samples the looped-back receive lines after a programmable latency.
- Counts mismatches per channel over a programmable packet length.
- Sits between the test-control register block and the RS-422 transceiver pins; generalises the single-channel toggle tester with channel count, PRBS mode, run-time packet length and latency, channel masking and abort.

Parameters:
NCH, 4, number of channels (1..64)
CNT_W, 16, width of packet-length and bit counter
ERR_W, 32, width of each per-channel error counter
LAT_W, 4, width of receive-latency setting

Ports:
sys_clk  in  1  clock, all logic rising-edge
sys_rst  in  1  reset, synchronous, active-high
start  in  1  begin test; sampled only in IDLE/DONE
abort  in  1  stop test early
mode  in  1  0 = toggle pattern, 1 = PRBS7
pkt_len  in  CNT_W  bits per test; latched on start
rx_lat  in  LAT_W  wait cycles between drive and sample; latched on start
chan_en  in  NCH  channel enable mask; latched on start
rs422_in  in  NCH  looped-back receive lines
rs422_di  out  NCH  transmit data lines, registered
busy  out  1  high from start-accept until DONE
finish  out  1  level; high in DONE until next accepted start
aborted  out  1  level; set if run ended by abort, cleared on start
bit_cnt  out  CNT_W  bits checked in current/last run
err_cnt  out  NCH*ERR_W  per-channel error counters, channel i at [i*ERR_W +: ERR_W]
err_any  out  1  OR of (err_cnt[i] != 0)

Behaviour:
- Reset (sync, sys_rst=1): state IDLE; rs422_di=0, busy=0, finish=0, aborted=0, bit_cnt=0, err_cnt=0, PRBS registers loaded with seeds.
- States: IDLE, SEND, WAIT, CHECK, DONE.
- Start from IDLE or DONE: latch pkt_len/rx_lat/chan_en/mode; clear err_cnt, bit_cnt, finish, aborted, rs422_di; reseed PRBS; go to SEND, or straight to DONE if pkt_len==0. busy=1 from the next cycle.
- SEND, 1 cycle: each enabled channel advances its pattern and registers the new bit on rs422_di. Disabled channels hold 0.
  - Toggle: bit = ~previous, so the first bit is 1.
  - PRBS7: x^7+x^6+1, seed 7'h7F ^ channel index; output is the LFSR MSB after shifting.
  - Next state: WAIT if rx_lat != 0, else CHECK.
- WAIT: exactly rx_lat cycles, then CHECK.
- CHECK, 1 cycle: for each enabled channel, rs422_in[i] != rs422_di[i] increments err_cnt[i], saturating at all-ones. bit_cnt increments. If the new bit_cnt == latched pkt_len, go to DONE; else go to SEND.
- Bit period = rx_lat + 2 cycles. Total run = pkt_len*(rx_lat+2) cycles from the first SEND.
- DONE: busy=0, finish=1, rs422_di holds its last value, counters hold. Next start re-runs the test; otherwise remain in DONE.
- Abort in SEND/WAIT/CHECK: next state DONE with aborted=1. A CHECK evaluated in the abort cycle is discarded: no count increment, no bit_cnt increment. Abort in IDLE/DONE is ignored.
- start together with abort: abort wins; start is not accepted.
- start while busy: ignored.
- Changes to pkt_len/rx_lat/chan_en/mode mid-run: no effect until the next start.
- pkt_len = 2^CNT_W-1 must complete without bit_cnt wrap.
- Reset mid-run: immediate return to reset values on the next edge, regardless of state.

Decomposition:
- Package rs422_pkg:
  - state enum
  - MODE_TOGGLE/MODE_PRBS7 constants
  - PRBS7 tap/seed constants
  - function returning the per-channel seed
- Sub-module rs422_pattern_gen: one instance per channel via generate. Inputs: sys_clk, sys_rst, load, adv, mode, seed. Output: bit.
- Top module holds the FSM, counters and compare logic.

Test Plan:
- NCH=4, toggle, pkt_len=8, rx_lat=2, rs422_in wired to rs422_di delayed 1 cycle -> finish after 32 cycles, err_cnt all 0, bit_cnt=8, rs422_di sequence 1,0,1,0...
- PRBS7, pkt_len=127, rx_lat=0, loopback -> 0 errors; channel 0 stream matches reference LFSR seeded 7'h7F and repeats at bit 128 in a second run.
- Channel 2 input forced 0, toggle, pkt_len=10 -> err_cnt[2]=5, others 0, err_any=1.
- chan_en=4'b1010, input stuck 1 -> channels 0 and 2 hold rs422_di=0 with err_cnt 0; channels 1 and 3 count mismatches.
- abort in WAIT of bit 5 (pkt_len=100) -> next cycle DONE, aborted=1, finish=1, bit_cnt=4; start with abort in same cycle is ignored.
- pkt_len=0 -> DONE one cycle after start with bit_cnt=0. sys_rst asserted mid-run -> all outputs 0 on the next edge.
